// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write controller: FSM state codes,
// io_lcd register field positions and the slow-executing opcodes.
package lcd_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_EXEC  = 3'd4;

  // io_lcd register field positions
  localparam int IO_ON_BIT   = 31;
  localparam int IO_GO_BIT   = 10;
  localparam int IO_RS_BIT   = 9;
  localparam int IO_RW_BIT   = 8;
  localparam int IO_DATA_MSB = 7;
  localparam int IO_DATA_LSB = 0;

  // Instructions that need the long execution wait (clear display, return home)
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  // One LCD write request: register select plus data byte
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_req_t;

  // Clear/home are instructions (RS=0); the same byte written as data is fast
  function automatic logic is_long_cmd(input lcd_req_t req);
    return !req.rs && ((req.data == CMD_CLEAR) || (req.data == CMD_HOME) ||
                       (req.data == CMD_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_req_slot.sv
// Single-entry pending buffer for LCD requests that arrive while a
// transfer is in progress. A push into a full slot is dropped and
// raises a sticky overflow flag; a push together with a pop refills
// the slot that is being freed, so nothing is lost in that case.
module lcd_req_slot
  import lcd_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  logic     pop_i,
  input  lcd_req_t req_i,
  output logic     full_o,
  output lcd_req_t req_o,
  output logic     ovf_o
);

  logic     valid_q, valid_d;
  lcd_req_t req_q, req_d;
  logic     ovf_q, ovf_d;

  // Next-state logic: pop first, then a push may refill or overflow
  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    ovf_d   = ovf_q;
    if (pop_i) begin
      valid_d = 1'b0;
    end
    if (push_i) begin
      if (valid_q && !pop_i) begin
        ovf_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        req_d   = req_i;
      end
    end
  end

  // Slot storage and sticky overflow, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      req_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
      ovf_q   <= ovf_d;
    end
  end

  assign full_o = valid_q;
  assign req_o  = req_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit write sequencer driven by the LSU io_lcd register.
// A rising edge on GO launches setup -> EN pulse -> hold -> execution
// wait; one further request can be queued while the controller is busy.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned EN_CYC        = 12,
  parameter int unsigned HOLD_CYC      = 4,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned EXEC_LONG_CYC = 82000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] io_lcd_i,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic        lcd_busy_o,
  output logic        lcd_ovf_o
);

  // Counter is sized for the longest wait; each phase loads (cycles - 1)
  localparam int unsigned CNT_W = $clog2(EXEC_LONG_CYC + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(EXEC_LONG_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lcd_req_t         act_q, act_d;
  logic             en_q, en_d;
  logic             go_q;
  logic             on_q;

  logic             req;
  lcd_req_t         new_req;
  logic             slot_push;
  logic             slot_pop;
  logic             slot_full;
  lcd_req_t         slot_req;
  logic             slot_ovf;

  // Bits of io_lcd that this controller deliberately ignores
  logic unused_io;
  assign unused_io = ^{io_lcd_i[30:11], io_lcd_i[IO_RW_BIT]};

  // Request decode: GO rising edge, with RS/DATA taken from the same write
  always_comb begin
    req          = io_lcd_i[IO_GO_BIT] & ~go_q;
    new_req.rs   = io_lcd_i[IO_RS_BIT];
    new_req.data = io_lcd_i[IO_DATA_MSB:IO_DATA_LSB];
  end

  // Transfer sequencer: phase timing, queueing and hand-off of the pending request
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    slot_push = 1'b0;
    slot_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LOAD;
          act_d   = new_req;
        end
      end
      ST_SETUP: begin
        slot_push = req;
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = EN_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        slot_push = req;
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        slot_push = req;
        if (cnt_q == '0) begin
          state_d = ST_EXEC;
          cnt_d   = is_long_cmd(act_q) ? LONG_LOAD : EXEC_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          if (slot_full) begin
            state_d   = ST_SETUP;
            cnt_d     = SETUP_LOAD;
            act_d     = slot_req;
            slot_pop  = 1'b1;
            slot_push = req;
          end else if (req) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LOAD;
            act_d   = new_req;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          slot_push = req;
          cnt_d     = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    en_d = (state_d == ST_PULSE);
  end

  // Sequencer registers; reset aborts any transfer and drops EN at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      act_q   <= '0;
      en_q    <= 1'b0;
      go_q    <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      en_q    <= en_d;
      go_q    <= io_lcd_i[IO_GO_BIT];
      on_q    <= io_lcd_i[IO_ON_BIT];
    end
  end

  lcd_req_slot u_slot (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (slot_push),
    .pop_i  (slot_pop),
    .req_i  (new_req),
    .full_o (slot_full),
    .req_o  (slot_req),
    .ovf_o  (slot_ovf)
  );

  assign lcd_data_o = act_q.data;
  assign lcd_rs_o   = act_q.rs;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = en_q;
  assign lcd_on_o   = on_q;
  assign lcd_busy_o = (state_q != ST_IDLE) | slot_full;
  assign lcd_ovf_o  = slot_ovf;

endmodule
